// File: rtl/db_strobe_cmp_if.sv
// Bus bundle for the db_strobe_cmp receive-side pin channel.
// WINDOW_STROBE_EN adds the STROBE_END window bound.
interface db_strobe_cmp_if #(
    parameter int CNT_W  = 10,
    parameter int FCNT_W = 16
);
    logic              EN;
    logic              LOAD_EXP;
    logic              TRANSFER_EXP;
    logic              EXP;
    logic              LOAD_MASK;
    logic              TRANSFER_MASK;
    logic              MASK;
    logic              DUT_IN;
    logic [CNT_W-1:0]  STROBE_EDGE_1;
    logic [CNT_W-1:0]  STROBE_EDGE_2;
    logic [CNT_W-1:0]  CYCLE_LENGTH;
    logic              TEST_CYCLE;
    logic              CLR_FAIL;
`ifdef WINDOW_STROBE_EN
    logic [CNT_W-1:0]  STROBE_END;
`endif
    logic              SAMPLE;
    logic              SAMPLE_VALID;
    logic              FAIL;
    logic              MASKED;
    logic              FAIL_STICKY;
    logic [FCNT_W-1:0] FAIL_COUNT;

    modport master (
`ifdef WINDOW_STROBE_EN
        output STROBE_END,
`endif
        output EN, LOAD_EXP, TRANSFER_EXP, EXP, LOAD_MASK, TRANSFER_MASK, MASK,
        output DUT_IN, STROBE_EDGE_1, STROBE_EDGE_2, CYCLE_LENGTH, TEST_CYCLE, CLR_FAIL,
        input  SAMPLE, SAMPLE_VALID, FAIL, MASKED, FAIL_STICKY, FAIL_COUNT
    );

    modport slave (
`ifdef WINDOW_STROBE_EN
        input  STROBE_END,
`endif
        input  EN, LOAD_EXP, TRANSFER_EXP, EXP, LOAD_MASK, TRANSFER_MASK, MASK,
        input  DUT_IN, STROBE_EDGE_1, STROBE_EDGE_2, CYCLE_LENGTH, TEST_CYCLE, CLR_FAIL,
        output SAMPLE, SAMPLE_VALID, FAIL, MASKED, FAIL_STICKY, FAIL_COUNT
    );
endinterface

// File: rtl/db_strobe_cmp.sv
// Receive-side tester pin channel: strobed compare against double-buffered expect/mask.
// WINDOW_STROBE_EN turns the single strobe edge into a strobe_edge..STROBE_END window.
module db_strobe_cmp #(
    parameter int CNT_W  = 10,
    parameter int FCNT_W = 16
) (
    input logic           CLK,
    input logic           RST_N,
    db_strobe_cmp_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              exp_buf_q, exp_buf_d, exp_act_q, exp_act_d;
    logic              mask_buf_q, mask_buf_d, mask_act_q, mask_act_d;
    logic              sample_q, sample_d, vld_q, vld_d;
    logic              fail_q, fail_d, masked_q, masked_d, sticky_q, sticky_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d, fcnt_base;
    logic              win_fail_q, win_fail_d;

    logic [CNT_W-1:0]  eff_len, last_cnt, strobe_edge, end_eff;
    logic              single, edge_ok, in_win, emit_pt, mism, acc_fail, look, do_emit;

    // A CYCLE_LENGTH of 0 behaves like 1: one clock per test cycle.
    always_comb begin
        eff_len     = (bus.CYCLE_LENGTH == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.CYCLE_LENGTH;
        last_cnt    = eff_len - 1'b1;
        single      = (eff_len == {{(CNT_W-1){1'b0}}, 1'b1});
        strobe_edge = bus.TEST_CYCLE ? bus.STROBE_EDGE_2 : bus.STROBE_EDGE_1;
        edge_ok     = (strobe_edge < eff_len);
`ifdef WINDOW_STROBE_EN
        end_eff = (bus.STROBE_END < strobe_edge) ? strobe_edge : bus.STROBE_END;
        if (end_eff > last_cnt)
            end_eff = last_cnt;
`else
        end_eff = strobe_edge;
`endif
        in_win  = edge_ok && (cnt_q >= strobe_edge) && (cnt_q <= end_eff);
        emit_pt = in_win && (cnt_q == end_eff);
        mism    = ~mask_act_q & (sync2_q ^ exp_act_q);
        acc_fail = ((cnt_q == strobe_edge) ? 1'b0 : win_fail_q) | mism;
    end

    always_comb begin
        sync1_d    = bus.DUT_IN;
        sync2_d    = sync1_q;
        exp_buf_d  = bus.LOAD_EXP ? bus.EXP : exp_buf_q;
        exp_act_d  = bus.TRANSFER_EXP ? exp_buf_q : exp_act_q;
        mask_buf_d = bus.LOAD_MASK ? bus.MASK : mask_buf_q;
        mask_act_d = bus.TRANSFER_MASK ? mask_buf_q : mask_act_q;
        if (!bus.EN || single || cnt_q >= last_cnt)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        look       = 1'b0;
        vld_d      = 1'b0;
        sample_d   = sample_q;
        fail_d     = fail_q;
        masked_d   = masked_q;
        sticky_d   = bus.CLR_FAIL ? 1'b0 : sticky_q;
        fcnt_base  = bus.CLR_FAIL ? '0 : fcnt_q;
        fcnt_d     = fcnt_base;
        win_fail_d = win_fail_q;

        case (state_q)
            ST_IDLE: if (bus.EN) state_d = ST_WAIT;
            ST_WAIT: begin
                look = 1'b1;
                if (emit_pt) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                // Single-clock cycles may strobe again straight away.
                if (single) begin
                    look    = 1'b1;
                    state_d = emit_pt ? ST_CAPT : ST_WAIT;
                end else if (cnt_q == '0 || cnt_q >= last_cnt) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (cnt_q >= last_cnt) state_d = ST_WAIT;
            default: state_d = ST_IDLE;
        endcase

        if (!bus.EN) begin
            state_d = ST_IDLE;
            look    = 1'b0;
        end

        do_emit = look && emit_pt;
        if (look && in_win)
            win_fail_d = acc_fail;
        if (do_emit) begin
            vld_d    = 1'b1;
            sample_d = sync2_q;
            fail_d   = acc_fail;
            masked_d = mask_act_q;
            // A fresh fail beats a simultaneous clear.
            if (acc_fail) begin
                sticky_d = 1'b1;
                fcnt_d   = (fcnt_base == '1) ? fcnt_base : fcnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            exp_buf_q  <= 1'b0;
            exp_act_q  <= 1'b0;
            mask_buf_q <= 1'b0;
            mask_act_q <= 1'b0;
            sample_q   <= 1'b0;
            vld_q      <= 1'b0;
            fail_q     <= 1'b0;
            masked_q   <= 1'b0;
            sticky_q   <= 1'b0;
            fcnt_q     <= '0;
            win_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            exp_buf_q  <= exp_buf_d;
            exp_act_q  <= exp_act_d;
            mask_buf_q <= mask_buf_d;
            mask_act_q <= mask_act_d;
            sample_q   <= sample_d;
            vld_q      <= vld_d;
            fail_q     <= fail_d;
            masked_q   <= masked_d;
            sticky_q   <= sticky_d;
            fcnt_q     <= fcnt_d;
            win_fail_q <= win_fail_d;
        end
    end

    assign bus.SAMPLE       = sample_q;
    assign bus.SAMPLE_VALID = vld_q;
    assign bus.FAIL         = fail_q;
    assign bus.MASKED       = masked_q;
    assign bus.FAIL_STICKY  = sticky_q;
    assign bus.FAIL_COUNT   = fcnt_q;
endmodule

// File: doc/db_strobe_cmp.md
Name: db_strobe_cmp

Overview:
- Receive-side pin channel of the ASIC tester: samples a DUT output once per test cycle at a programmable strobe edge and compares it against a double-buffered expected value and mask.
- Reports per-cycle pass/fail, a sticky fail flag and a saturating fail count.
- Mirrors the drive-side formatter channel: same cycle counter semantics, same LOAD/TRANSFER double-buffer scheme, same TEST_CYCLE edge select.

Parameters:
- CNT_W, 10, width of the edge and cycle-length values.
- FCNT_W, 16, width of the fail counter.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- EN  in  1  active-high run enable for the cycle counter.
- LOAD_EXP  in  1  loads EXP into the expected buffer.
- TRANSFER_EXP  in  1  copies the expected buffer to the active expected register.
- EXP  in  1  expected DUT value.
- LOAD_MASK  in  1  loads MASK into the mask buffer.
- TRANSFER_MASK  in  1  copies the mask buffer to the active mask register.
- MASK  in  1  1 = do not compare this cycle.
- DUT_IN  in  1  asynchronous DUT pin value.
- STROBE_EDGE_1  in  CNT_W  strobe count used when TEST_CYCLE=0.
- STROBE_EDGE_2  in  CNT_W  strobe count used when TEST_CYCLE=1.
- CYCLE_LENGTH  in  CNT_W  number of clocks in one test cycle.
- TEST_CYCLE  in  1  selects the strobe edge.
- CLR_FAIL  in  1  clears FAIL_STICKY and FAIL_COUNT.
- SAMPLE  out  1  last captured DUT value.
- SAMPLE_VALID  out  1  one-clock pulse; SAMPLE, FAIL and MASKED are updated.
- FAIL  out  1  result of the last compare.
- MASKED  out  1  last compare was masked.
- FAIL_STICKY  out  1  set on any fail, held until CLR_FAIL or reset.
- FAIL_COUNT  out  FCNT_W  saturating count of failing cycles.

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - Clears every register: buffers, active registers, synchroniser, counter, all outputs.
  - FSM goes to IDLE.
  - Reset mid-cycle aborts any pending strobe; no SAMPLE_VALID is issued.
- Synchroniser:
  - DUT_IN passes through 2 flops. The sampled value is the synchronised value, so pin-to-sample latency is 2 clocks.
  - Bench edges are programmed with this offset.
- Double buffers:
  - LOAD_x captures the input into the buffer; TRANSFER_x copies the buffer into the active register.
  - If LOAD_x and TRANSFER_x occur in the same clock, the active register receives the old buffer value.
  - The expected and mask paths are independent.
- Cycle counter cnt:
  - While EN=1, cnt runs 0..CYCLE_LENGTH-1 and then wraps to 0.
  - CYCLE_LENGTH of 0 or 1: cnt stays at 0 and a strobe can occur every clock.
  - EN=0: cnt is forced to 0 and the FSM returns to IDLE.
- Strobe edge:
  - strobe_edge = TEST_CYCLE ? STROBE_EDGE_2 : STROBE_EDGE_1, evaluated combinationally in the clock where the match is tested.
  - strobe_edge >= CYCLE_LENGTH: no strobe that cycle; all outputs hold.
- FSM states:
  - IDLE: EN=1 -> WAIT.
  - WAIT: cnt==strobe_edge -> CAPT. Capture the synchronised DUT, the active expected value and the active mask in this clock.
  - CAPT: compute the compare.
    - SAMPLE_VALID=1 for exactly one clock.
    - FAIL = ~mask & (sample ^ exp).
    - MASKED = mask.
    - Next state is DONE.
  - DONE: wait for cnt wrap (cnt==CYCLE_LENGTH-1) -> WAIT.
  - Result: at most one strobe per test cycle.
  - Single-clock cycles (CYCLE_LENGTH<=1): CAPT goes straight to WAIT.
- Compare latency: outputs update 1 clock after the strobe-match clock. SAMPLE, FAIL and MASKED hold until the next compare.
- Fail counter:
  - On a compare with FAIL=1, FAIL_COUNT increments and saturates at all-ones; FAIL_STICKY is set.
  - CLR_FAIL in the same clock as a new fail: the fail wins, giving FAIL_COUNT=1 and FAIL_STICKY=1.

Optional Feature:
- Macro: WINDOW_STROBE_EN.
- Defined:
  - Adds input STROBE_END (CNT_W).
  - The compare becomes a window: every clock with strobe_edge <= cnt <= STROBE_END is compared.
  - FAIL is the OR of mismatches across the window. SAMPLE is the last sample taken in the window.
  - SAMPLE_VALID pulses 1 clock after the cnt==STROBE_END clock.
  - STROBE_END < strobe_edge: degrades to single-edge behaviour.
- Undefined: single-edge compare as described above; the STROBE_END port is absent.

Test Plan:
- Single-edge pass:
  - Setup: CYCLE_LENGTH=10, STROBE_EDGE_1=5, EXP=1 loaded and transferred, MASK=0, DUT_IN=1 held.
  - Response: SAMPLE_VALID pulses once per 10 clocks, FAIL=0, FAIL_COUNT=0.
- Fail and sticky clear:
  - Stimulus: EXP=0 with DUT_IN=1, run 3 cycles.
  - Response: FAIL=1 on each compare, FAIL_COUNT=3, FAIL_STICKY=1.
  - Then CLR_FAIL for 1 clock -> FAIL_COUNT=0, FAIL_STICKY=0.
- Mask and edge select:
  - Stimulus: MASK=1 with a mismatching DUT value -> FAIL=0, MASKED=1.
  - TEST_CYCLE=1 with STROBE_EDGE_2=2 and a DUT pulse high only at cnt 2 (pin-adjusted) -> SAMPLE=1.
- Double buffer:
  - Stimulus: LOAD_EXP with EXP=1, then LOAD_EXP with EXP=0 in the same clock as TRANSFER_EXP.
  - Response: active expected = 1.
- Boundaries:
  - STROBE_EDGE_1=12, CYCLE_LENGTH=10 -> no SAMPLE_VALID.
  - CYCLE_LENGTH=1 -> SAMPLE_VALID every clock.
  - FAIL_COUNT preset near max via forced fails -> saturates at 16'hFFFF.
- Reset and enable:
  - RST_N=0 at cnt=4 with strobe at 5 -> no SAMPLE_VALID; all outputs 0.
  - EN dropped mid-cycle -> cnt=0; the next strobe occurs 5 clocks after EN returns.
